// File: rtl/aes_key_expand_if.sv
// Round-key stream between the key expander (master) and the AES round datapath (slave).
// The master holds round_key/rk_idx/rk_last stable while rk_valid is high and rk_ready is low.
interface aes_key_expand_if;
  logic [127:0] round_key;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;

  modport master (output round_key, rk_idx, rk_valid, rk_last, input rk_ready);
  modport slave  (input round_key, rk_idx, rk_valid, rk_last, output rk_ready);
endinterface

// File: rtl/aes_key_expand.sv
// Word-serial AES-128/192/256 key expansion that streams round keys 0..Nr with backpressure.
// Optional AES_KEY_STORE_EN keeps a 15-entry round-key store readable through rd_idx/rd_key.
module aes_key_expand #(
  parameter int MAX_NK = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [255:0]     key,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [3:0]       rd_idx,
  output logic [127:0]     rd_key,
  aes_key_expand_if.master rk
);
  typedef enum logic {IDLE, EXPAND} state_e;

  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Entry x sits at bit 8*(255-x), and 255-x is simply ~x for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_e         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [3:0]     nk_q, nk_d, nr_q, nr_d;
  logic [31:0]    win_q [MAX_NK];
  logic [31:0]    win_d [MAX_NK];
  logic [5:0]     wi_q, wi_d;
  logic [2:0]     wmod_q, wmod_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [31:0]    col_q [4];
  logic [31:0]    col_d [4];
  logic [2:0]     col_cnt_q, col_cnt_d;
  logic [3:0]     rk_idx_q, rk_idx_d;
  logic           done_q, done_d, err_q, err_d;

  logic [3:0]     nk_sel, nr_sel;
  logic [5:0]     n_words;
  logic [31:0]    key_word, w_back, t, word;
  logic           start_ok, rk_valid, last, hs, gen, from_key;

  always_comb begin
    nk_sel   = 4'd4 + {1'b0, mode, 1'b0};
    nr_sel   = nk_sel + 4'd6;
    start_ok = (mode != 2'd3) && (nk_sel <= MAX_NK_W);

    rk_valid = (col_cnt_q == 3'd4);
    last     = rk_valid && (rk_idx_q == nr_q);
    hs       = rk_valid && rk.rk_ready;
    n_words  = {nr_q + 4'd1, 2'b00};
    // A handshake frees the collector this cycle, so only a refused full collector stalls.
    gen      = (state_q == EXPAND) && (wi_q < n_words) && (!rk_valid || rk.rk_ready);
    from_key = (wi_q < {2'b00, nk_q});

    key_word = '0;
    for (int k = 0; k < 8; k++)
      if (wi_q == 6'(k)) key_word = key_q[255-32*k -: 32];
    w_back = '0;
    for (int k = 0; k < MAX_NK; k++)
      if (4'(k) == nk_q - 4'd1) w_back = win_q[k];

    t = win_q[0];
    if (wmod_q == 3'd0)
      t = subword({win_q[0][23:0], win_q[0][31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && wmod_q == 3'd4)
      t = subword(win_q[0]);
    word = from_key ? key_word : (w_back ^ t);
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    nk_d      = nk_q;
    nr_d      = nr_q;
    win_d     = win_q;
    wi_d      = wi_q;
    wmod_d    = wmod_q;
    rcon_d    = rcon_q;
    col_d     = col_q;
    col_cnt_d = col_cnt_q;
    rk_idx_d  = rk_idx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && start_ok) begin
          state_d   = EXPAND;
          key_d     = key;
          nk_d      = nk_sel;
          nr_d      = nr_sel;
          wi_d      = '0;
          wmod_d    = '0;
          rcon_d    = 8'h01;
          col_cnt_d = '0;
          rk_idx_d  = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      EXPAND: begin
        if (gen) begin
          wi_d   = wi_q + 6'd1;
          // nk_q[2:0] - 1 is 3/5/7 for Nk = 4/6/8.
          wmod_d = (wmod_q == nk_q[2:0] - 3'd1) ? 3'd0 : wmod_q + 3'd1;
          if (wmod_q == 3'd0 && !from_key) rcon_d = xtime(rcon_q);
          win_d[0] = word;
          for (int k = 1; k < MAX_NK; k++) win_d[k] = win_q[k-1];
          col_d[0] = col_q[1];
          col_d[1] = col_q[2];
          col_d[2] = col_q[3];
          col_d[3] = word;
        end
        if (hs)       col_cnt_d = gen ? 3'd1 : 3'd0;
        else if (gen) col_cnt_d = col_cnt_q + 3'd1;
        if (hs) begin
          rk_idx_d = last ? 4'd0 : rk_idx_q + 4'd1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      win_q     <= '{default: '0};
      wi_q      <= '0;
      wmod_q    <= '0;
      rcon_q    <= '0;
      col_q     <= '{default: '0};
      col_cnt_q <= '0;
      rk_idx_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      nk_q      <= nk_d;
      nr_q      <= nr_d;
      win_q     <= win_d;
      wi_q      <= wi_d;
      wmod_q    <= wmod_d;
      rcon_q    <= rcon_d;
      col_q     <= col_d;
      col_cnt_q <= col_cnt_d;
      rk_idx_q  <= rk_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy         = (state_q == EXPAND);
  assign done         = done_q;
  assign err          = err_q;
  assign rk.rk_valid  = rk_valid;
  assign rk.rk_last   = last;
  assign rk.rk_idx    = rk_idx_q;
  assign rk.round_key = rk_valid ? {col_q[0], col_q[1], col_q[2], col_q[3]} : '0;

`ifdef AES_KEY_STORE_EN
  // Kept across starts so a decryptor can read the schedule back in reverse.
  logic [127:0] store_q [15];
  logic [127:0] rd_key_q, rd_key_d;

  always_comb rd_key_d = (rd_idx > 4'd14) ? '0 : store_q[rd_idx];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      store_q  <= '{default: '0};
      rd_key_q <= '0;
    end else begin
      if (hs) store_q[rk_idx_q] <= rk.round_key;
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: a FIPS-197 style key-schedule model drives a per-cycle
// stream checker, with literal round keys pinning the model.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start = 1'b0, start4 = 1'b0;
  logic [1:0]   mode = 2'd0, mode4 = 2'd0;
  logic [255:0] key = '0;
  logic [3:0]   rd_idx = 4'd0;
  logic         busy, done, err, busy4, done4, err4;
  logic [127:0] rd_key, rd_key4;

  aes_key_expand_if rkif ();
  aes_key_expand_if rkif4 ();

  aes_key_expand #(.MAX_NK(8)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .mode(mode), .key(key),
    .busy(busy), .done(done), .err(err), .rd_idx(rd_idx), .rd_key(rd_key), .rk(rkif)
  );

  aes_key_expand #(.MAX_NK(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .start(start4), .mode(mode4), .key(key),
    .busy(busy4), .done(done4), .err(err4), .rd_idx(rd_idx), .rd_key(rd_key4), .rk(rkif4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    s = 8'h63;
    for (int r = 0; r < 5; r++) s = s ^ 8'((inv << r) | (inv >> (8 - r)));
    return s;
  endfunction

  function automatic logic [31:0] subw_m(input logic [31:0] w);
    return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
  endfunction

  logic [127:0] exp_rk [0:14];
  int           exp_nr = 0;
  int           exp_ptr = 99;
  int           acc_cyc = 0;
  bit           stall_mode = 1'b0;

  task automatic build_model(input logic [1:0] m, input logic [255:0] k);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * int'(m);
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw_m(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    exp_nr = nr;
  endtask

  // Key bytes 00,01,... left-aligned; the unused tail is filled with a5 to show it is ignored.
  function automatic logic [255:0] seq_key(input int nbytes);
    logic [255:0] k;
    for (int b = 0; b < 32; b++) k[255 - 8*b -: 8] = (b < nbytes) ? 8'(b) : 8'ha5;
    return k;
  endfunction

  // ---------------- stream checker ----------------
  bit           done_exp = 1'b0, prev_stall = 1'b0;
  logic [127:0] prev_key = '0;

  always @(negedge clk) begin
    if (!nrst) begin
      done_exp       = 1'b0;
      prev_stall     = 1'b0;
      rkif.rk_ready  = 1'b0;
    end else begin
      chk("done", 128'(done), 128'(done_exp));
      done_exp = 1'b0;
      if (rkif.rk_valid) begin
        if (exp_ptr > exp_nr) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_key: got rk_valid with rk_idx %0d, required no key", rkif.rk_idx);
        end else begin
          chk("round_key", rkif.round_key, exp_rk[exp_ptr]);
          chk("rk_idx", 128'(rkif.rk_idx), 128'(exp_ptr));
          chk("rk_last", 128'(rkif.rk_last), 128'(exp_ptr == exp_nr));
          if (prev_stall) chk("stall_hold", rkif.round_key, prev_key);
          if (!stall_mode) chk("latency", 128'(cyc - acc_cyc), 128'(4 * (exp_ptr + 1)));
        end
        rkif.rk_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        prev_stall    = !rkif.rk_ready;
        prev_key      = rkif.round_key;
        if (rkif.rk_ready) begin
          if (exp_ptr == exp_nr) done_exp = 1'b1;
          exp_ptr++;
        end
      end else begin
        prev_stall    = 1'b0;
        rkif.rk_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input logic [1:0] m, input logic [255:0] k, input bit stl);
    @(negedge clk);
    build_model(m, k);
    exp_ptr    = 0;
    stall_mode = stl;
    acc_cyc    = cyc + 1;
    mode       = m;
    key        = k;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = ~k;
    chk("busy_after_start", 128'(busy), 128'd1);
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clk);
      #2;
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: got no done pulse within %0d cycles, required one", budget);
    end else begin
      chk("busy_at_done", 128'(busy), 128'd0);
      chk("keys_total", 128'(exp_ptr), 128'(exp_nr + 1));
    end
  endtask

  task automatic reject(input string name, input bit use4, input logic [1:0] m);
    @(negedge clk);
    if (use4) begin mode4 = m; start4 = 1'b1; end
    else      begin mode  = m; start  = 1'b1; end
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
    chk({name, "_err"},  128'(use4 ? err4 : err), 128'd1);
    chk({name, "_busy"}, 128'(use4 ? busy4 : busy), 128'd0);
    @(negedge clk);
    chk({name, "_err_clear"}, 128'(use4 ? err4 : err), 128'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_ctl"}, 128'({busy, done, err, rkif.rk_valid, rkif.rk_last, rkif.rk_idx}), 128'd0);
    chk({name, "_round_key"}, rkif.round_key, 128'd0);
    chk({name, "_rd_key"}, rd_key, 128'd0);
  endtask

  logic [255:0] fips_key;

  initial begin
    rkif4.rk_ready = 1'b1;
    fips_key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_0badf00d_12345678_9abcdef0};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    nrst = 1'b1;

    // AES-128 FIPS-197 key, consumer always ready.
    build_model(2'd0, fips_key);
    chk("model_fips_r1",  exp_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    launch(2'd0, fips_key, 1'b0);
    wait_done(80);

    @(negedge clk);
    rd_idx = 4'd10;
    @(negedge clk);
`ifdef AES_KEY_STORE_EN
    chk("store_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd0;
    @(negedge clk);
    chk("store_r0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_idx = 4'd15;
    @(negedge clk);
    chk("store_idx15", rd_key, 128'd0);
`else
    chk("no_store_rd_key", rd_key, 128'd0);
`endif

    // AES-192 then AES-256, the second started in the done cycle of the first.
    launch(2'd1, seq_key(24), 1'b0);
    chk("model_192_r12", exp_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    wait_done(100);
    launch(2'd2, seq_key(32), 1'b0);
    chk("model_256_r14", exp_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    wait_done(100);

    // AES-128 under random backpressure, with a start attempt while busy.
    launch(2'd0, seq_key(16), 1'b1);
    chk("model_seq128_r10", exp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    repeat (5) @(negedge clk);
    mode  = 2'd2;
    key   = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_no_err", 128'(err), 128'd0);
    chk("busy_start_busy", 128'(busy), 128'd1);
    wait_done(400);

    reject("mode3", 1'b0, 2'd3);
    reject("maxnk4_mode2", 1'b1, 2'd2);
    chk("dut4_ctl", 128'({busy4, done4, rkif4.rk_valid, rkif4.rk_last, rkif4.rk_idx}), 128'd0);
    chk("dut4_round_key", rkif4.round_key, 128'd0);
    chk("dut4_rd_key", rd_key4, 128'd0);

    // Reset in the middle of an expansion, then a clean rerun from r0.
    launch(2'd0, fips_key, 1'b0);
    for (int c = 0; c < 100 && exp_ptr < 6; c++) begin
      @(posedge clk);
      #2;
    end
    chk("reached_r5", 128'(exp_ptr >= 6), 128'd1);
    #1 nrst = 1'b0;
    #1 check_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_release");
    launch(2'd0, fips_key, 1'b0);
    wait_done(80);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Parametrised AES key expansion engine supporting AES-128, AES-192 and AES-256, selected at run time per request.
- Streams round keys 0..Nr in order, one 128-bit key per handshake, with valid/ready backpressure.
- Feeds the round datapath of the AES cores; replaces per-round in-place key update with a word-serial generator.

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8). Modes needing Nk > MAX_NK are rejected. Key input width is fixed at 256.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE.
- mode  input  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=reserved.
- key  input  256  cipher key, left-aligned: w0=key[255:224]; unused low bits ignored.
- busy  output  1  high from accepted start until last key handshake.
- round_key  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rk_idx  output  4  round index r of round_key.
- rk_valid  output  1  round_key valid.
- rk_ready  input  1  consumer accepts round_key.
- rk_last  output  1  high with rk_valid when rk_idx == Nr.
- done  output  1  one-cycle pulse after last handshake.
- err  output  1  one-cycle pulse on rejected start.
- rd_idx  input  4  store read index (optional feature).
- rd_key  output  128  store read data (optional feature).

Behaviour:
- Reset (nrst low, async): state IDLE; all outputs 0; word window, counters, Rcon and store cleared.
- States: IDLE -> EXPAND on valid start. EXPAND -> IDLE on handshake with rk_last. No other transitions.
- Start validation:
  - start in IDLE with mode==3, or with Nk > MAX_NK, is ignored and pulses err the next cycle.
  - start while busy is ignored with no err.
  - key and mode are captured on the accepting edge.
- Word generation: one word per non-stalled cycle, i = 0..4(Nr+1)-1 (44/52/60 words).
  - i < Nk: w[i] is copied from key.
  - i >= Nk: t = w[i-1].
    - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {Rcon, 24'h0}.
    - Else if Nk == 8 and i mod 8 == 4: t = SubWord(t).
    - w[i] = w[i-Nk] ^ t.
  - i mod Nk is a wrap counter, not a divider.
  - Rcon starts at 8'h01 and advances by GF(2^8) xtime after each use (01,02,04,...,80,1b,36).
  - The last Nk words are held in a shift window of MAX_NK words.
- Collection:
  - Each word enters a 4-word collector.
  - When the collector is full, rk_valid=1 and round_key/rk_idx are held stable until rk_ready.
- Stall: rk_valid && !rk_ready freezes word generation, counters and Rcon.
- Overlap:
  - A handshake frees the collector in the same cycle.
  - The next word is accepted that same cycle, with no bubble.
- Latency:
  - rk_valid for r=0 asserts 4 cycles after the accepting edge.
  - With rk_ready tied high, a new key follows every 4 cycles.
  - The last key appears 4(Nr+1) cycles after start.
- Completion:
  - The handshake with rk_last returns to IDLE.
  - busy falls and done pulses the next cycle.
  - A new start is accepted in that same cycle as done.
- Reset mid-expansion aborts immediately. No partial key is presented after release.
- rk_idx counts 0..Nr and never wraps.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- Defined:
  - A 15 x 128 store writes round_key at rk_idx on each handshake.
  - rd_key = store[rd_idx], registered, 1-cycle latency.
  - rd_idx > 14 returns 0.
  - The store is not cleared on start, only on reset. This allows reverse-order reads for decryption.
- Undefined: no storage; rd_key is constant 0 and rd_idx is ignored.

Test Plan:
- mode=0, key=2b7e151628aed2a6abf7158809cf4f3c (left-aligned), rk_ready=1 -> r1 = a0fafe1788542cb123a339392a6c7605, r10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last. done follows; 11 keys total, one every 4 cycles.
- mode=1, key=000102...1617 -> 13 keys; r12 = a4970a331a78dc09c418c271e3a41d5d.
- mode=2, key=000102...1e1f -> 15 keys; r14 = 24fc79ccbf0979e9371ac23c6d68de36.
- mode=0, key=000102...0f, random rk_ready stalls -> same key sequence, r10 = 13111d7fe3944a17f307a78b4d2b30c5. round_key is held stable during stalls; a second start while busy is ignored.
- MAX_NK=4 with mode=2, or mode=3 -> err pulse, busy stays 0. nrst low after r5 -> all outputs 0; a following mode=0 start repeats from r0.
- AES_KEY_STORE_EN defined, after the mode=0 run: rd_idx=10 -> rd_key = d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; rd_idx=15 -> 0.
